aes_round_key_fetch: RTL and testbench

AES_ROUND_KEY_FETCH -- requirements
Module: aes_round_key_fetch

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_rk_shiftreg.sv | 19 +
 rtl/aes_round_key_fetch.sv | 149 ++++++++++++++
 tb/tb_aes_round_key_fetch.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES round-key fetch types, constants and Nr lookup
package aes_pkg;

   // Round-key fetch controller states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PRESENT = 2'd2
   } rkf_state_t;

   // 32-bit words that make up one 128-bit round key
   localparam int WORDS_PER_RK = 4;

   // Key memory word address width (60 words max, 0..59)
   localparam int KEY_ADDR_W = 6;

   // Number of rounds for the given key length code
   function automatic logic [3:0] nr_from_length(input logic [1:0] length);
      case (length)
         2'b10:   return 4'd12;
         2'b11:   return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

endpackage

// File: rtl/aes_rk_shiftreg.sv
// rtl/aes_rk_shiftreg.sv - 128-bit round-key assembler, 32-bit words shifted in from the right
module aes_rk_shiftreg (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_en,
   input  logic [31:0]  din,
   output logic [127:0] q
);

   // First word loaded ends up in the top 32 bits after four loads
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= '0;
      end else if (load_en) begin
         q <= {q[95:0], din};
      end
   end

endmodule

// File: rtl/aes_round_key_fetch.sv
// rtl/aes_round_key_fetch.sv - fetches expanded round keys from key memory, one per handshake; AES_RKF_DECRYPT_EN adds dir and descending order
module aes_round_key_fetch
   import aes_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            length,
   input  logic                  keydone,
   input  logic                  rk_start,
`ifdef AES_RKF_DECRYPT_EN
   input  logic                  dir,
`endif
   input  logic                  rk_next,
   input  logic [31:0]           mem_rdata,
   output logic [KEY_ADDR_W-1:0] mem_addr,
   output logic                  mem_rd_en,
   output logic [127:0]          round_key,
   output logic                  rk_valid,
   output logic [3:0]            round_idx,
   output logic                  rk_last,
   output logic                  busy,
   output logic                  err
);

   rkf_state_t state;
   logic [2:0] cnt;
   logic [3:0] r;
   logic [3:0] nr_q;
   logic       dir_q;
   logic       dir_sel;
   logic [3:0] start_r;
   logic [3:0] r_nxt;
   logic       shift_en;

`ifdef AES_RKF_DECRYPT_EN
   assign dir_sel = dir;
`else
   assign dir_sel = 1'b0;
`endif

   assign start_r = dir_sel ? nr_from_length(length) : 4'd0;
   assign r_nxt   = dir_q ? (r - 4'd1) : (r + 4'd1);

   // Read data lags its address by one cycle, so capture runs on cnt 1..4
   assign shift_en = (state == ST_FETCH) && (cnt != 3'd0) && keydone;

   aes_rk_shiftreg u_shiftreg (
      .clk     (clk),
      .rst     (rst),
      .load_en (shift_en),
      .din     (mem_rdata),
      .q       (round_key)
   );

   // Sequence controller: issue four reads per round, present the key, step the round
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         r         <= '0;
         nr_q      <= '0;
         dir_q     <= 1'b0;
         mem_addr  <= '0;
         mem_rd_en <= 1'b0;
         rk_valid  <= 1'b0;
         round_idx <= '0;
         rk_last   <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rk_start) begin
                  if (keydone) begin
                     state     <= ST_FETCH;
                     busy      <= 1'b1;
                     r         <= start_r;
                     round_idx <= start_r;
                     nr_q      <= nr_from_length(length);
                     dir_q     <= dir_sel;
                     mem_addr  <= {start_r, 2'b00};
                     mem_rd_en <= 1'b1;
                     cnt       <= '0;
                     rk_last   <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            ST_FETCH: begin
               if (!keydone) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  rk_valid  <= 1'b0;
                  rk_last   <= 1'b0;
                  mem_rd_en <= 1'b0;
               end else begin
                  cnt <= cnt + 3'd1;
                  if (cnt < 3'(WORDS_PER_RK - 1)) begin
                     mem_addr <= mem_addr + 6'd1;
                  end else begin
                     mem_rd_en <= 1'b0;
                  end
                  if (cnt == 3'(WORDS_PER_RK)) begin
                     state    <= ST_PRESENT;
                     rk_valid <= 1'b1;
                     rk_last  <= dir_q ? (r == 4'd0) : (r == nr_q);
                  end
               end
            end

            ST_PRESENT: begin
               if (!keydone) begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  rk_valid  <= 1'b0;
                  rk_last   <= 1'b0;
                  mem_rd_en <= 1'b0;
               end else if (rk_next) begin
                  rk_valid <= 1'b0;
                  if (rk_last) begin
                     state   <= ST_IDLE;
                     busy    <= 1'b0;
                     rk_last <= 1'b0;
                  end else begin
                     state     <= ST_FETCH;
                     r         <= r_nxt;
                     round_idx <= r_nxt;
                     mem_addr  <= {r_nxt, 2'b00};
                     mem_rd_en <= 1'b1;
                     cnt       <= '0;
                  end
               end
            end

            default: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               rk_valid  <= 1'b0;
               rk_last   <= 1'b0;
               mem_rd_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_key_fetch.sv
// tb/tb_aes_round_key_fetch.sv - self-checking bench with AES key-expansion reference model
module tb_aes_round_key_fetch;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   length;
   logic         keydone;
   logic         rk_start;
   logic         dir_i;
   logic         rk_next;
   logic [31:0]  mem_rdata;
   logic [5:0]   mem_addr;
   logic         mem_rd_en;
   logic [127:0] round_key;
   logic         rk_valid;
   logic [3:0]   round_idx;
   logic         rk_last;
   logic         busy;
   logic         err;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:63];
   logic [7:0]  sbox [0:255];

   always #5 clk = ~clk;

   aes_round_key_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .length    (length),
      .keydone   (keydone),
      .rk_start  (rk_start),
`ifdef AES_RKF_DECRYPT_EN
      .dir       (dir_i),
`endif
      .rk_next   (rk_next),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .round_key (round_key),
      .rk_valid  (rk_valid),
      .round_idx (round_idx),
      .rk_last   (rk_last),
      .busy      (busy),
      .err       (err)
   );

   // Key memory: data returned one cycle after the address
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic int nr_of(input logic [1:0] len);
      return (len == 2'b11) ? 14 : (len == 2'b10) ? 12 : 10;
   endfunction

   // FIPS-197 key expansion into the key memory model; unused words get noise
   task automatic expand(input logic [255:0] key, input logic [1:0] len);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk, total;
      nk = nr_of(len) - 6;
      total = 4 * (nr_of(len) + 1);
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      rc = 8'h01;
      for (int i = 0; i < total; i++) begin
         if (i < nk) begin
            w[i] = key[255 - 32 * i -: 32];
         end else begin
            t = w[i - 1];
            if (i % nk == 0) begin
               t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end else if (nk > 6 && i % nk == 4) begin
               t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
         end
         mem[i] = w[i];
      end
   endtask

   function automatic logic [127:0] exp_key(input int r);
      return {mem[4 * r], mem[4 * r + 1], mem[4 * r + 2], mem[4 * r + 3]};
   endfunction

   task automatic check_zero(input string pfx);
      check({pfx, "_round_key"}, round_key, 128'h0);
      check({pfx, "_rk_valid"}, 128'(rk_valid), 128'h0);
      check({pfx, "_rk_last"}, 128'(rk_last), 128'h0);
      check({pfx, "_round_idx"}, 128'(round_idx), 128'h0);
      check({pfx, "_mem_addr"}, 128'(mem_addr), 128'h0);
      check({pfx, "_mem_rd_en"}, 128'(mem_rd_en), 128'h0);
      check({pfx, "_busy"}, 128'(busy), 128'h0);
      check({pfx, "_err"}, 128'(err), 128'h0);
   endtask

   // Runs one sequence; hold<0 means random 0..3 cycle consumer stall per key
   task automatic run_seq(input logic [1:0] len, input logic d, input int hold, input int abort_round,
                          output int nkeys, output logic [127:0] first_key, output logic [127:0] last_key,
                          output int first_idx, output int last_idx, output int first_addr);
      int nr, r, lat, h;
      logic [5:0] aq [$];
      logic [127:0] ek;
      nr = nr_of(len);
      r = d ? nr : 0;
      nkeys = 0; first_key = '0; last_key = '0; first_idx = -1; last_idx = -1; first_addr = -1;
      @(negedge clk);
      length = len; dir_i = d; rk_start = 1'b1;
      for (int k = 0; k <= nr; k++) begin
         lat = 0;
         aq.delete();
         while (1) begin
            @(negedge clk);
            rk_start = 1'b0;
            rk_next = 1'b0;
            if (rk_valid) break;
            if (mem_rd_en) aq.push_back(mem_addr);
            check("busy_fetch", 128'(busy), 128'h1);
            check("err_busy", 128'(err), 128'h0);
            lat++;
            if (abort_round == r && lat == 2) begin
               keydone = 1'b0;
               @(negedge clk);
               check("abort_busy", 128'(busy), 128'h0);
               check("abort_rk_valid", 128'(rk_valid), 128'h0);
               check("abort_rd_en", 128'(mem_rd_en), 128'h0);
               check("abort_rk_last", 128'(rk_last), 128'h0);
               keydone = 1'b1;
               return;
            end
            if (lat > 12) begin
               check("timeout_rk_valid", 128'(0), 128'(1));
               return;
            end
            rk_next = ($urandom_range(0, 3) == 0);
            rk_start = ($urandom_range(0, 3) == 0);
         end
         ek = exp_key(r);
         check("latency", 128'(lat), 128'(5));
         check("addr_count", 128'(aq.size()), 128'(4));
         for (int i = 0; i < aq.size(); i++) check("addr", 128'(aq[i]), 128'(4 * r + i));
         check("round_key", round_key, ek);
         check("round_idx", 128'(round_idx), 128'(r));
         check("rk_last", 128'(rk_last), 128'(k == nr));
         check("rd_en_present", 128'(mem_rd_en), 128'h0);
         if (k == 0) begin
            first_key = round_key; first_idx = int'(round_idx);
            first_addr = (aq.size() > 0) ? int'(aq[0]) : -1;
         end
         last_key = round_key; last_idx = int'(round_idx);
         nkeys++;
         h = (hold < 0) ? $urandom_range(0, 3) : hold;
         for (int i = 0; i < h; i++) begin
            @(negedge clk);
            check("hold_key", round_key, ek);
            check("hold_valid", 128'(rk_valid), 128'h1);
            check("hold_idx", 128'(round_idx), 128'(r));
            check("hold_rd_en", 128'(mem_rd_en), 128'h0);
         end
         rk_next = 1'b1;
         r = d ? r - 1 : r + 1;
      end
      @(negedge clk);
      rk_next = 1'b0;
      check("end_busy", 128'(busy), 128'h0);
      check("end_rk_valid", 128'(rk_valid), 128'h0);
      check("end_rk_last", 128'(rk_last), 128'h0);
   endtask

   initial begin
      int nk, fi, li, fa, lat;
      logic [127:0] fk, lk;
      logic [1:0] len;
      logic d;
      rst = 1'b0; length = 2'b00; keydone = 1'b0; rk_start = 1'b0; dir_i = 1'b0; rk_next = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      build_sbox();
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;

      // Start without an expanded key: err pulse, no reads
      @(negedge clk);
      rk_start = 1'b1;
      @(negedge clk);
      rk_start = 1'b0;
      check("nokey_err", 128'(err), 128'h1);
      check("nokey_busy", 128'(busy), 128'h0);
      check("nokey_rd_en", 128'(mem_rd_en), 128'h0);
      @(negedge clk);
      check("nokey_err_pulse", 128'(err), 128'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("nokey_rd_en_idle", 128'(mem_rd_en), 128'h0);
      end

      // AES-128 FIPS-197 key, consumer takes every key at once
      keydone = 1'b1;
      expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00);
      run_seq(2'b00, 1'b0, 0, -1, nk, fk, lk, fi, li, fa);
      check("aes128_nkeys", 128'(nk), 128'(11));
      check("aes128_first", fk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      check("aes128_last", lk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("aes128_last_idx", 128'(li), 128'(10));

      // AES-256 ascending reaches the top of memory
      expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'b11);
      run_seq(2'b11, 1'b0, -1, -1, nk, fk, lk, fi, li, fa);
      check("aes256_nkeys", 128'(nk), 128'(15));
      check("aes256_last_idx", 128'(li), 128'(14));

`ifdef AES_RKF_DECRYPT_EN
      // AES-256 descending: first fetch at 56..59, ends on round 0
      run_seq(2'b11, 1'b1, 0, -1, nk, fk, lk, fi, li, fa);
      check("dec_nkeys", 128'(nk), 128'(15));
      check("dec_first_idx", 128'(fi), 128'(14));
      check("dec_last_idx", 128'(li), 128'(0));
      check("dec_first_addr", 128'(fa), 128'(56));
`endif

      // AES-192 with a 20-cycle consumer stall on every key
      expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0}, 2'b10);
      run_seq(2'b10, 1'b0, 20, -1, nk, fk, lk, fi, li, fa);
      check("aes192_nkeys", 128'(nk), 128'(13));

      // Random key sizes and orders
      for (int t = 0; t < 6; t++) begin
         len = 2'($urandom_range(0, 3));
`ifdef AES_RKF_DECRYPT_EN
         d = 1'($urandom_range(0, 1));
`else
         d = 1'b0;
`endif
         expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, len);
         run_seq(len, d, -1, -1, nk, fk, lk, fi, li, fa);
         check("rand_nkeys", 128'(nk), 128'(nr_of(len) + 1));
      end

      // keydone drops during the fetch of round 3
      expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00);
      run_seq(2'b00, 1'b0, 0, 3, nk, fk, lk, fi, li, fa);
      check("abort_nkeys", 128'(nk), 128'(3));

      // Reset while a key is presented
      @(negedge clk);
      length = 2'b01; rk_start = 1'b1;
      lat = 0;
      @(negedge clk);
      rk_start = 1'b0;
      while (!rk_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("rst_reached_present", 128'(rk_valid), 128'h1);
      rst = 1'b0;
      @(negedge clk);
      check_zero("midrst");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_valid", 128'(rk_valid), 128'h0);
      check("post_rst_busy", 128'(busy), 128'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
